irq_priority_controller: RTL and testbench
==========================================

IRQ_PRIORITY_CONTROLLER -- requirements
Module: irq_priority_controller

Interface
REQ-001 The block SHALL have parameter N_SRC, default 16, the number of interrupt sources (2..16).
REQ-002 The block SHALL have parameter CAUSE_BASE, default 32'h8000_0010, the mcause value for source 0.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 irq_req_i  in  N_SRC  level interrupt requests from peripherals, bit i = source i.
REQ-007 irq_mask_i  in  N_SRC  enable mask; 1 = source may be granted.
REQ-008 irq_ret_i  in  1  one-cycle pulse from the core on mret completion.
REQ-009 irq_o  out  1  interrupt request to the core.
REQ-010 irq_cause_o  out  32  mcause value of the served source.
REQ-011 irq_ret_o  out  N_SRC  one-hot, one-cycle acknowledge to the served peripheral.

Function
REQ-012 The FSM SHALL have two states: IDLE and BUSY.
REQ-013 In IDLE, if (irq_req_i & irq_mask_i) != 0, the block SHALL latch the winning index into id_q and enter BUSY on the next edge.
REQ-014 Winner selection without the Configuration macro SHALL be fixed priority: lowest index wins.
REQ-015 irq_o SHALL be 1 exactly while the state is BUSY (registered, one-cycle latency from request to irq_o).
REQ-016 irq_cause_o SHALL equal CAUSE_BASE + id_q while BUSY and 0 in IDLE; the add is 32-bit, zero-extended id_q, no overflow check.
REQ-017 In BUSY, irq_ret_i = 1 SHALL produce irq_ret_o = (1 << id_q) on the next cycle for exactly one cycle and return the state to IDLE.
REQ-018 Deassertion of irq_req_i[id_q] or of irq_mask_i[id_q] during BUSY SHALL NOT abort service; the latched id_q is kept until irq_ret_i.
REQ-019 irq_ret_i in IDLE SHALL be ignored: no irq_ret_o pulse and no state change.
REQ-020 Requests arriving during BUSY SHALL NOT be granted (no nesting); they are evaluated on re-entry to IDLE.
REQ-021 After a return, at least one IDLE cycle SHALL occur before the next grant, so irq_o drops for at least one cycle between services.
REQ-022 irq_req_i & irq_mask_i == 0 in IDLE SHALL keep the block in IDLE with irq_o = 0.

Reset
REQ-023 rst_ni = 0 SHALL immediately set the state to IDLE, id_q = 0, irq_o = 0, irq_cause_o = 0, irq_ret_o = 0, and the rotation pointer = 0, independent of clk_i.
REQ-024 Reset during BUSY SHALL discard the service silently, with no irq_ret_o pulse emitted before or after reset release.
REQ-025 The first grant SHALL be possible at the first rising edge after rst_ni rises.

Configuration
REQ-026 Macro IRQ_ROUND_ROBIN_EN SHALL control the arbitration scheme.
REQ-027 When IRQ_ROUND_ROBIN_EN is defined, the block SHALL keep a pointer ptr_q (log2 N_SRC bits) and grant the first eligible index searching upward from ptr_q with wrap-around N_SRC-1 -> 0.
REQ-028 When IRQ_ROUND_ROBIN_EN is defined, on each irq_ret_o pulse ptr_q SHALL become (id_q + 1) mod N_SRC.
REQ-029 When IRQ_ROUND_ROBIN_EN is undefined, the block SHALL use fixed priority per REQ-014, with no pointer logic synthesised.

Verification
REQ-030 Reset, then irq_req_i = 16'h0008, mask = 16'hFFFF -> irq_o = 1 one cycle later with irq_cause_o = 32'h8000_0013; irq_ret_i pulse -> irq_ret_o = 16'h0008 for one cycle, then irq_o = 0.
REQ-031 irq_req_i = 16'h0024, mask = 16'hFFFF, fixed priority -> source 2 served first (cause 32'h8000_0012), then source 5 (cause 32'h8000_0015) after ≥1 IDLE cycle.
REQ-032 irq_req_i = 16'h0004, mask = 16'hFFFB -> irq_o stays 0 for 50 cycles; irq_ret_i pulses produce no irq_ret_o.
REQ-033 Assert source 1, grant, drop irq_req_i[1] and raise irq_req_i[0] during BUSY -> cause stays 32'h8000_0011 until irq_ret_i; source 0 is granted only after return.
REQ-034 Pull rst_ni low while BUSY on source 7 -> irq_o and irq_cause_o are 0 immediately, and no irq_ret_o pulse ever appears for source 7.
REQ-035 With IRQ_ROUND_ROBIN_EN defined and irq_req_i = 16'h8001 held, four services -> grant order 0, 15, 0, 15; without the macro -> 0, 0, 0, 0.

Source files
------------

// File: rtl/irq_priority_controller.sv
// Interrupt priority controller: arbitrates masked level requests, holds one
// service at a time until the core signals mret completion, then acknowledges
// the served source with a one-cycle one-hot pulse.
// Optional macro IRQ_ROUND_ROBIN_EN selects round-robin arbitration; without it
// the lowest eligible index always wins.
module irq_priority_controller #(
  parameter int unsigned N_SRC      = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] irq_req_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             irq_ret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_SRC-1:0] irq_ret_o
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     id_q, id_d;
  logic              irq_q, irq_d;
  logic [31:0]       cause_q, cause_d;
  logic [N_SRC-1:0]  ret_q, ret_d;
  logic [N_SRC-1:0]  elig;
  logic [IW-1:0]     win_id;
  logic              win_vld;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0]     ptr_q, ptr_d;
  int unsigned       idx;

  // Round-robin winner: first eligible index at or above ptr_q, wrapping to 0
  always_comb begin
    elig    = irq_req_i & irq_mask_i;
    win_id  = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!win_vld && elig[IW'(idx)]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end
`else
  // Fixed-priority winner: lowest eligible index
  always_comb begin
    elig    = irq_req_i & irq_mask_i;
    win_id  = '0;
    win_vld = |elig;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[IW'(i)]) win_id = IW'(i);
    end
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ret_d   = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          id_d    = win_id;
        end
      end
      BUSY: begin
        // Service is held on the latched id regardless of request/mask changes
        if (irq_ret_i) begin
          state_d   = IDLE;
          ret_d[id_q] = 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
          ptr_d   = (id_q == IW'(N_SRC - 1)) ? '0 : id_q + IW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d   = (state_d == BUSY);
    cause_d = irq_d ? (CAUSE_BASE + 32'(id_d)) : 32'h0;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      irq_q   <= 1'b0;
      cause_q <= '0;
      ret_q   <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign irq_o       = irq_q;
  assign irq_cause_o = cause_q;
  assign irq_ret_o   = ret_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Testbench for irq_priority_controller: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_irq_priority_controller;

  localparam int unsigned N    = 16;
  localparam logic [31:0] BASE = 32'h8000_0010;
`ifdef IRQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          ret;
  logic          irq;
  logic [31:0]   cause;
  logic [N-1:0]  ret_o;

  int checks = 0;
  int errors = 0;

  // Reference model: which source is in service and where round-robin resumes
  bit            m_busy;
  int unsigned   m_id;
  int unsigned   m_ptr;
  logic [N-1:0]  m_ret;

  irq_priority_controller #(.N_SRC(N), .CAUSE_BASE(BASE)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .irq_req_i   (req),
    .irq_mask_i  (mask),
    .irq_ret_i   (ret),
    .irq_o       (irq),
    .irq_cause_o (cause),
    .irq_ret_o   (ret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned pick(input logic [N-1:0] e);
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = RR ? (int'(m_ptr) + k) % int'(N) : k;
      if (e[4'(j)]) return int'(j);
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_ptr  = 0;
    m_ret  = '0;
  endtask

  // One clock: drive inputs, advance model at the edge, compare at negedge
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] m, input logic rt);
    logic [N-1:0] e;
    req  = r;
    mask = m;
    ret  = rt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_ret = '0;
      if (m_busy) begin
        if (rt) begin
          m_busy = 1'b0;
          m_ret  = N'(1) << m_id;
          m_ptr  = (m_id + 1) % N;
        end
      end else begin
        e = r & m;
        if (e != '0) begin
          m_busy = 1'b1;
          m_id   = pick(e);
        end
      end
    end
    @(negedge clk);
    check("irq_o", 32'(irq), 32'(m_busy));
    check("irq_cause_o", cause, m_busy ? BASE + 32'(m_id) : 32'h0);
    check("irq_ret_o", 32'(ret_o), 32'(m_ret));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    ret   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] order [4];
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    ret   = 1'b0;
    model_reset();
    #1;
    check("reset_irq_o", 32'(irq), 32'h0);
    check("reset_cause", cause, 32'h0);
    check("reset_ret_o", 32'(ret_o), 32'h0);
    do_reset();

    // Single source 3: grant, return, acknowledge
    cycle(16'h0008, 16'hFFFF, 1'b0);
    check("s3_irq", 32'(irq), 32'h1);
    check("s3_cause", cause, 32'h8000_0013);
    cycle(16'h0008, 16'hFFFF, 1'b1);
    check("s3_ack", 32'(ret_o), 32'h0008);
    check("s3_irq_drop", 32'(irq), 32'h0);
    cycle(16'h0000, 16'hFFFF, 1'b0);
    check("s3_ack_once", 32'(ret_o), 32'h0);

    // Two sources: 2 first, then 5 after an idle cycle (fixed priority)
    do_reset();
    cycle(16'h0024, 16'hFFFF, 1'b0);
    if (!RR) check("s2_first", cause, 32'h8000_0012);
    cycle(16'h0020, 16'hFFFF, 1'b1);
    check("gap_idle", 32'(irq), 32'h0);
    cycle(16'h0020, 16'hFFFF, 1'b0);
    check("s5_second", cause, 32'h8000_0015);
    cycle(16'h0000, 16'hFFFF, 1'b1);

    // Masked source: never granted, stray returns ignored
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cycle(16'h0004, 16'hFFFB, 1'($urandom_range(0, 1)));
      check("masked_irq", 32'(irq), 32'h0);
    end

    // Request change during service does not disturb the latched id
    do_reset();
    cycle(16'h0002, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0001, 16'hFFFF, 1'b0);
      check("hold_cause", cause, 32'h8000_0011);
    end
    cycle(16'h0001, 16'hFFFF, 1'b1);
    check("hold_ack", 32'(ret_o), 32'h0002);
    cycle(16'h0001, 16'hFFFF, 1'b0);
    check("s0_after", cause, 32'h8000_0010);
    cycle(16'h0000, 16'hFFFF, 1'b1);

    // Reset during service on source 7 discards it silently
    do_reset();
    cycle(16'h0080, 16'hFFFF, 1'b0);
    check("s7_busy", cause, 32'h8000_0017);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_irq_now", 32'(irq), 32'h0);
    check("rst_cause_now", cause, 32'h0);
    check("rst_ret_now", 32'(ret_o), 32'h0);
    @(negedge clk);
    cycle(16'h0000, 16'hFFFF, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0000, 16'hFFFF, 1'b1);
      check("no_s7_ack", 32'(ret_o), 32'h0);
    end

    // Sources 0 and 15 held: grant order depends on arbitration scheme
    do_reset();
    for (int s = 0; s < 4; s++) begin
      cycle(16'h8001, 16'hFFFF, 1'b0);
      order[s] = cause;
      cycle(16'h8001, 16'hFFFF, 1'b1);
    end
    for (int s = 0; s < 4; s++) begin
      check("grant_order", order[s],
            (RR && (s % 2 == 1)) ? 32'h8000_001F : 32'h8000_0010);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] r, m;
      r = (i % 3 == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      m = N'($urandom | $urandom);
      cycle(r, m, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
